// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the banked matrix multiplier.
//   mm_state_e : controller state encoding
//   acc_w()    : accumulator width that cannot overflow for an N-term dot product
//   k_of()     : number of dot-product terms handled by each bank (N / BANKS)
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MAC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_STORE = 3'd4,
    ST_FIN   = 3'd5
  } mm_state_e;

  // Each product is at most 2*width bits; summing n of them adds clog2(n) bits.
  function automatic int acc_w(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  function automatic int k_of(input int n, input int banks);
    return n / banks;
  endfunction

endpackage

// File: rtl/mm_mac_tree.sv
// mm_mac_tree: BANKS parallel unsigned multipliers feeding a registered sum.
//   clk, resetn   : clock, asynchronous active-low reset (valid only)
//   vld_p0        : operands on a_data_p0 / b_data_p0 are valid this cycle
//   a_data_p0     : lane b operand on bits [b*WIDTH +: WIDTH]
//   b_data_p0     : lane b operand on bits [b*WIDTH +: WIDTH]
//   vld_p1        : sum_p1 holds the sum of the operands presented one cycle earlier
//   sum_p1        : registered sum of the BANKS products
module mm_mac_tree #(
  parameter int WIDTH = 8,
  parameter int BANKS = 2,
  parameter int SUM_W = 18
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   vld_p0,
  input  logic [BANKS*WIDTH-1:0] a_data_p0,
  input  logic [BANKS*WIDTH-1:0] b_data_p0,
  output logic                   vld_p1,
  output logic [SUM_W-1:0]       sum_p1
);

  logic [SUM_W-1:0] sum_p0;

  always_comb begin
    sum_p0 = '0;
    for (int b = 0; b < BANKS; b++) begin
      sum_p0 = sum_p0 + SUM_W'(a_data_p0[b*WIDTH +: WIDTH]) * SUM_W'(b_data_p0[b*WIDTH +: WIDTH]);
    end
  end

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    sum_p1 <= sum_p0;
  end

endmodule

// File: rtl/mm_banked.sv
// mm_banked: computes RES = A x B (M x N by N x P) using BANKS parallel MAC lanes.
// Each result element walks K = N/BANKS shared addresses across all banks,
// accumulates the lane sums and writes a WIDTH-bit slice of the accumulator.
//   clk, resetn          : clock, asynchronous active-low reset
//   Start                : level request; a rising edge seen in IDLE starts a run
//   Done                 : high from the cycle after the last write until Start drops
//   A_read_en/address    : shared read port to all A banks; data returns next cycle
//   A_read_data_out      : bank b data on bits [b*WIDTH +: WIDTH]
//   B_read_en/address    : shared read port to all B banks; data returns next cycle
//   B_read_data_out      : bank b data on bits [b*WIDTH +: WIDTH]
//   RES_write_en         : one-cycle strobe per result element
//   RES_write_address    : i*P + k
//   RES_write_data_in    : acc[SHIFT +: WIDTH]
// Build option MM_SATURATE_EN: clamp the result to all-ones when accumulator
// bits above the written slice are set, instead of truncating.
module mm_banked
  import mm_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int A_DEPTH_BITS   = 9,
  parameter int B_DEPTH_BITS   = 9,
  parameter int RES_DEPTH_BITS = 9,
  parameter int M              = 64,
  parameter int N              = 8,
  parameter int P              = 2,
  parameter int BANKS          = 2,
  parameter int SHIFT          = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      Start,
  output logic                      Done,
  output logic                      A_read_en,
  output logic [A_DEPTH_BITS-1:0]   A_read_address,
  input  logic [BANKS*WIDTH-1:0]    A_read_data_out,
  output logic                      B_read_en,
  output logic [B_DEPTH_BITS-1:0]   B_read_address,
  input  logic [BANKS*WIDTH-1:0]    B_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_DEPTH_BITS-1:0] RES_write_address,
  output logic [WIDTH-1:0]          RES_write_data_in
);

  localparam int K     = k_of(N, BANKS);
  localparam int ACC_W = acc_w(WIDTH, N);
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int KW    = $clog2(K + 1);

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [KW-1:0] J_LAST = KW'(K - 1);

  mm_state_e          state, state_nxt;
  logic               start_q;
  logic               start_rise;
  logic [IW-1:0]      i_cnt;
  logic [PW-1:0]      k_cnt;
  logic [KW-1:0]      j_cnt;
  logic               fl_cnt;
  logic               last_elem;
  logic               rd_en;
  logic               vld_p0;
  logic               vld_p1;
  logic [ACC_W-1:0]   sum_p1;
  logic [ACC_W-1:0]   acc;

  // Select the result slice; with MM_SATURATE_EN, clamp when the slice
  // cannot represent the accumulator.
  function automatic logic [WIDTH-1:0] res_scale(input logic [ACC_W-1:0] a);
`ifdef MM_SATURATE_EN
    logic ovf;
    ovf = 1'b0;
    for (int b = SHIFT + WIDTH; b < ACC_W; b++) begin
      ovf = ovf | a[b];
    end
    return ovf ? {WIDTH{1'b1}} : WIDTH'(a >> SHIFT);
`else
    return WIDTH'(a >> SHIFT);
`endif
  endfunction

  assign start_rise = Start & ~start_q;
  assign last_elem  = (i_cnt == I_LAST) && (k_cnt == P_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_rise) state_nxt = ST_FILL;
      ST_FILL:  state_nxt = (K == 1) ? ST_FLUSH : ST_MAC;
      ST_MAC:   if (j_cnt == J_LAST) state_nxt = ST_FLUSH;
      // Two flush cycles: one for the final memory read, one for the tree register.
      ST_FLUSH: if (fl_cnt) state_nxt = ST_STORE;
      ST_STORE: state_nxt = last_elem ? ST_FIN : ST_FILL;
      ST_FIN:   if (!Start) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Start detector resets high so a Start held through reset is not a rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      start_q <= 1'b1;
      i_cnt   <= '0;
      k_cnt   <= '0;
      j_cnt   <= '0;
      fl_cnt  <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= Start;
      case (state)
        ST_FILL:  j_cnt  <= KW'(1);
        ST_MAC:   j_cnt  <= j_cnt + KW'(1);
        ST_FLUSH: fl_cnt <= ~fl_cnt;
        ST_STORE: begin
          j_cnt  <= '0;
          fl_cnt <= 1'b0;
          // k is the fastest index; both wrap so the next run starts at (0,0).
          if (k_cnt == P_LAST) begin
            k_cnt <= '0;
            i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + IW'(1);
          end else begin
            k_cnt <= k_cnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en             = (state == ST_FILL) || (state == ST_MAC);
  assign A_read_en         = rd_en;
  assign B_read_en         = rd_en;
  assign A_read_address    = A_DEPTH_BITS'(32'(i_cnt) * 32'(K) + 32'(j_cnt));
  assign B_read_address    = B_DEPTH_BITS'(32'(j_cnt) * 32'(P) + 32'(k_cnt));
  assign RES_write_en      = (state == ST_STORE);
  assign RES_write_address = RES_DEPTH_BITS'(32'(i_cnt) * 32'(P) + 32'(k_cnt));
  assign RES_write_data_in = res_scale(acc);
  assign Done              = (state == ST_FIN);

  // ---- stage p0: memory data returned for the address issued last cycle ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_en;
    end
  end

  mm_mac_tree #(
    .WIDTH (WIDTH),
    .BANKS (BANKS),
    .SUM_W (ACC_W)
  ) u_mac_tree (
    .clk       (clk),
    .resetn    (resetn),
    .vld_p0    (vld_p0),
    .a_data_p0 (A_read_data_out),
    .b_data_p0 (B_read_data_out),
    .vld_p1    (vld_p1),
    .sum_p1    (sum_p1)
  );

  // ---- stage p1 -> accumulator ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (state == ST_FILL) begin
      acc <= '0;
    end else if (vld_p1) begin
      acc <= acc + sum_p1;
    end
  end

endmodule

// File: doc/mm_banked.md
MM_BANKED -- requirements
Module: mm_banked

Interface
REQ-001 SHALL have parameter WIDTH, default 8, element and result width in bits.
REQ-002 SHALL have parameter A_DEPTH_BITS, default 9, A bank address width.
REQ-003 SHALL have parameter B_DEPTH_BITS, default 9, B bank address width.
REQ-004 SHALL have parameter RES_DEPTH_BITS, default 9, result memory address width.
REQ-005 SHALL have parameters M, N, P, defaults 64, 8, 2, giving A as M x N, B as N x P and RES as M x P.
REQ-006 SHALL have parameter BANKS, default 2, the number of parallel MAC lanes; it must divide N; K = N/BANKS.
REQ-007 SHALL have parameter SHIFT, default 8, the LSB of the accumulator slice written to RES.
REQ-008 Ports, in order:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- Start  in  1  level request; run begins on a 0->1 transition seen while in IDLE.
- Done  out  1  run complete.
- A_read_en  out  1  shared read enable for all A banks.
- A_read_address  out  A_DEPTH_BITS  shared address for all A banks.
- A_read_data_out  in  BANKS*WIDTH  bank b data on bits [b*WIDTH +: WIDTH].
- B_read_en, B_read_address, B_read_data_out  as for A, using B_DEPTH_BITS.
- RES_write_en  out  1  one-cycle write strobe.
- RES_write_address  out  RES_DEPTH_BITS  result address.
- RES_write_data_in  out  WIDTH  result data.

Function
REQ-009 A bank b SHALL hold A[i][b*K+j] at address i*K+j; B bank b SHALL hold B[b*K+j][k] at address j*P+k; RES[i][k] SHALL be written at address i*P+k.
REQ-010 Memories are synchronous: data appears on *_read_data_out the cycle after its address is driven.
REQ-011 FSM states: IDLE, FILL, MAC, FLUSH, STORE, FIN.
- IDLE -> FILL on a Start rise.
- FILL issues address j=0.
- MAC issues j=1..K-1 while accumulating returned data.
- FLUSH absorbs the last read and the adder-tree register.
- STORE writes one result.
- STORE -> FILL for the next (i,k), k fastest.
- STORE -> FIN after (M-1,P-1).
- FIN -> IDLE when Start = 0.
REQ-012 Each cycle SHALL sum BANKS unsigned products in a registered adder tree; partial sums are accumulated into acc.
REQ-013 acc SHALL be ACC_W = 2*WIDTH + clog2(N) bits and SHALL never overflow.
REQ-014 Each result element SHALL take exactly K+3 cycles from its FILL cycle to its STORE cycle inclusive; the whole run takes M*P*(K+3) cycles from the first FILL to the last STORE.
REQ-015 RES_write_en SHALL be high for exactly one cycle per element, in STORE, with address and data valid in that same cycle.
REQ-016 acc SHALL clear in FILL, so there is no carry-over between elements.
REQ-017 Done SHALL assert the cycle after the final STORE and hold through FIN; it deasserts on entry to IDLE.
REQ-018 Start SHALL be ignored outside IDLE; a Start held high after FIN SHALL NOT start a new run.
REQ-019 A_read_en and B_read_en SHALL be high only in FILL and MAC.

Reset
REQ-020 resetn low SHALL asynchronously force:
- state to IDLE;
- Done, all read enables and RES_write_en to 0;
- all addresses, RES_write_data_in, counters and acc to 0;
- the Start edge detector to 1, so a Start held high through reset does not launch a run.
REQ-021 A reset mid-run SHALL abort the run with no further RES writes; the next run restarts at (0,0).

Configuration
REQ-022 With MM_SATURATE_EN defined, RES_write_data_in SHALL be all-ones if any acc bit above SHIFT+WIDTH-1 is set, and acc[SHIFT+WIDTH-1:SHIFT] otherwise.
REQ-023 Without MM_SATURATE_EN, RES_write_data_in SHALL be acc[SHIFT+WIDTH-1:SHIFT], truncated.

Structure
REQ-024 Package mm_pkg SHALL hold the FSM state encoding, the ACC_W function and the K derivation.
REQ-025 Sub-module mm_mac_tree SHALL hold the BANKS-lane multiply and registered adder tree, with one cycle of latency.

Verification
REQ-026 Defaults with M=2, P=2, N=4, BANKS=2, all A=16, all B=16 -> four writes of value 4 at addresses 0..3, each K+3 = 5 cycles apart; Done rises one cycle after the last write.
REQ-027 All A=255, all B=255, N=4 -> value 255 with MM_SATURATE_EN defined; value 248 (0xF8) without it.
REQ-028 Random 8-bit A and B, BANKS in {1, 2, 4}, N=8 -> RES matches a reference model, and all BANKS settings produce identical RES contents.
REQ-029 resetn pulsed low during the third element -> no further writes; Start 0->1 then restarts at address 0 and completes correctly.
REQ-030 Start held high after Done -> no second run; Start toggled low then high -> exactly one new run.
